joy_pad_encoder: RTL and testbench

Parallel-to-serial joystick source for the ZXDOS+ Megadrive joystick port. It emulates the external shift-register board plus two Megadrive pads as seen by the joystick decoder. It accepts two 12-bit pad states and the select line (driven by the decoder from hsync_n). It answers the decoder's joy_load_n/joy_clk/joy_data scan with the select-dependent Megadrive 3/6-button pin patterns. It serves as the synthesizable loop-back source for board bring-up and as the bench driver for the decoder.

---
 rtl/joy_pad_encoder.sv | 143 ++++++++++++++
 tb/tb_joy_pad_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_pad_encoder.sv
// joy_pad_encoder: emulates the Megadrive shift-register board plus two pads.
// Two 12-bit pad states (MXYZ SACB RLDU, active low) are turned into the
// select/phase-dependent pin sets and serialised on the decoder's
// joy_load_n / joy_clk scan. All scan inputs are treated as asynchronous.
module joy_pad_encoder #(
  parameter int unsigned PRE_BITS = 2,
  parameter int unsigned GAP_BITS = 2,
  parameter logic [15:0] TIMEOUT  = 16'd40000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joy1_i,
  input  logic [11:0] joy2_i,
  input  logic [1:0]  six_btn,
  input  logic        joy_sel,
  input  logic        joy_clk,
  input  logic        joy_load_n,
  output logic        joy_data,
  output logic [1:0]  joy1_phase,
  output logic [1:0]  joy2_phase
);

  localparam int unsigned FRAME_LEN = PRE_BITS + 6 + GAP_BITS + 6;

  // Synchronizer and edge-detect stages
  logic r_sel_s1, r_sel_s2, r_sel_d;
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_ld_s1,  r_ld_s2,  r_ld_d;

  logic w_sel_rise, w_sel_edge, w_clk_rise, w_load_n;

  // Per-pad 6-button phase and idle counter
  logic [1:0][1:0]  r_phase, w_phase_d;
  logic [1:0][15:0] r_idle,  w_idle_d;

  // Pin sets {p9, p6, R, L, D, U} and the frame they load into
  logic [5:0]           w_pins1, w_pins2;
  logic [FRAME_LEN-1:0] r_frame, w_frame_load;

  // Pin pattern a Megadrive pad presents for a given select level and phase.
  function automatic logic [5:0] pad_pins(input logic [11:0] j, input logic sel,
                                          input logic [1:0] ph);
    logic [5:0] pins;
    if (sel) begin
      if (ph == 2'd3) pins = {j[5], j[4], j[11], j[10], j[9], j[8]};
      else            pins = {j[5], j[4], j[3], j[2], j[1], j[0]};
    end else begin
      unique case (ph)
        2'd2:    pins = {j[7], j[6], 4'b0000};
        2'd3:    pins = {j[7], j[6], 4'b1111};
        default: pins = {j[7], j[6], 2'b00, j[1], j[0]};
      endcase
    end
    return pins;
  endfunction

  // Two-flop synchronizers followed by one edge-detect register per input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_s1 <= 1'b1;
      r_sel_s2 <= 1'b1;
      r_sel_d  <= 1'b1;
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_d  <= 1'b0;
      r_ld_s1  <= 1'b1;
      r_ld_s2  <= 1'b1;
      r_ld_d   <= 1'b1;
    end else begin
      r_sel_s1 <= joy_sel;
      r_sel_s2 <= r_sel_s1;
      r_sel_d  <= r_sel_s2;
      r_clk_s1 <= joy_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_ld_s1  <= joy_load_n;
      r_ld_s2  <= r_ld_s1;
      r_ld_d   <= r_ld_s2;
    end
  end

  assign w_sel_rise = r_sel_s2 & ~r_sel_d;
  assign w_sel_edge = r_sel_s2 ^ r_sel_d;
  assign w_clk_rise = r_clk_s2 & ~r_clk_d;
  assign w_load_n   = r_ld_s2;

  // Next phase and idle count; a select edge beats the timeout in the same cycle
  always_comb begin
    w_phase_d = r_phase;
    w_idle_d  = r_idle;
    for (int p = 0; p < 2; p++) begin
      if (w_sel_edge)                w_idle_d[p] = '0;
      else if (r_idle[p] < TIMEOUT)  w_idle_d[p] = r_idle[p] + 16'd1;

      if (!six_btn[p]) begin
        w_phase_d[p] = 2'd0;
      end else if (w_sel_rise) begin
        w_phase_d[p] = (r_idle[p] >= TIMEOUT) ? 2'd0 : r_phase[p] + 2'd1;
      end else if (!w_sel_edge && (w_idle_d[p] == TIMEOUT)) begin
        w_phase_d[p] = 2'd0;
      end
    end
  end

  // Phase and idle counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_idle  <= '0;
    end else begin
      r_phase <= w_phase_d;
      r_idle  <= w_idle_d;
    end
  end

  assign w_pins1 = pad_pins(joy1_i, r_sel_s2, r_phase[0]);
  assign w_pins2 = pad_pins(joy2_i, r_sel_s2, r_phase[1]);

  // Parallel-load image: padding ones, then each pad with p9 nearest bit 0
  always_comb begin
    w_frame_load = '1;
    for (int i = 0; i < 6; i++) begin
      w_frame_load[PRE_BITS + i]                = w_pins1[5 - i];
      w_frame_load[PRE_BITS + 6 + GAP_BITS + i] = w_pins2[5 - i];
    end
  end

  // Frame shift register; a held load overrides any shift request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '1;
    end else if (!w_load_n) begin
      r_frame <= w_frame_load;
    end else if (w_clk_rise) begin
      r_frame <= {1'b1, r_frame[FRAME_LEN-1:1]};
    end
  end

  assign joy_data   = r_frame[0];
  assign joy1_phase = r_phase[0];
  assign joy2_phase = r_phase[1];

endmodule

// File: tb/tb_joy_pad_encoder.sv
// Bench for joy_pad_encoder: directed scans with literal expectations plus a
// cycle-by-cycle comparison against a behavioural pad/shift-board model.
module tb_joy_pad_encoder;

  localparam int TO   = 400;
  localparam int PRE  = 2;
  localparam int GAP  = 2;
  localparam int NBIT = PRE + 6 + GAP + 6;

  logic        clk;
  logic        reset_n;
  logic [11:0] joy1_i, joy2_i;
  logic [1:0]  six_btn;
  logic        joy_sel, joy_clk, joy_load_n;
  logic        joy_data;
  logic [1:0]  joy1_phase, joy2_phase;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  joy_pad_encoder #(
    .PRE_BITS(PRE),
    .GAP_BITS(GAP),
    .TIMEOUT (16'(TO))
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .joy1_i    (joy1_i),
    .joy2_i    (joy2_i),
    .six_btn   (six_btn),
    .joy_sel   (joy_sel),
    .joy_clk   (joy_clk),
    .joy_load_n(joy_load_n),
    .joy_data  (joy_data),
    .joy1_phase(joy1_phase),
    .joy2_phase(joy2_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The decoder-side view of each pin lags the pin by two clocks; an edge is
  // seen when that lagged view differs from the one a clock earlier.
  logic [3:1] m_sel_h, m_clk_h, m_ld_h;
  int         m_k, m_last_edge;
  int         m_phase [2];
  bit         m_frame [$];

  function automatic logic [5:0] m_pins(input logic [11:0] j, input logic sel, input int ph);
    logic u, d, l, r, b, c, a, s, z, y, x, m;
    {m, x, y, z, s, a, c, b, r, l, d, u} = j;
    if (sel) return (ph == 3) ? {c, b, m, x, y, z} : {c, b, r, l, d, u};
    if (ph == 3) return {s, a, 4'b1111};
    if (ph == 2) return {s, a, 4'b0000};
    return {s, a, 1'b0, 1'b0, d, u};
  endfunction

  task automatic m_reset();
    m_sel_h = 3'b111;
    m_clk_h = 3'b000;
    m_ld_h  = 3'b111;
    m_k = 0;
    m_last_edge = 0;
    m_phase[0] = 0;
    m_phase[1] = 0;
    m_frame.delete();
    repeat (NBIT) m_frame.push_back(1'b1);
  endtask

  task automatic m_step();
    logic sel_lvl, sel_rise, sel_edge, clk_rise, ld_lvl;
    logic [5:0] p1, p2;
    int idle_before;
    sel_lvl  = m_sel_h[2];
    sel_rise = m_sel_h[2] & ~m_sel_h[3];
    sel_edge = m_sel_h[2] ^ m_sel_h[3];
    clk_rise = m_clk_h[2] & ~m_clk_h[3];
    ld_lvl   = m_ld_h[2];
    m_k++;
    if (!ld_lvl) begin
      p1 = m_pins(joy1_i, sel_lvl, m_phase[0]);
      p2 = m_pins(joy2_i, sel_lvl, m_phase[1]);
      m_frame.delete();
      repeat (PRE) m_frame.push_back(1'b1);
      for (int i = 5; i >= 0; i--) m_frame.push_back(p1[i]);
      repeat (GAP) m_frame.push_back(1'b1);
      for (int i = 5; i >= 0; i--) m_frame.push_back(p2[i]);
    end else if (clk_rise) begin
      void'(m_frame.pop_front());
      m_frame.push_back(1'b1);
    end
    idle_before = m_k - 1 - m_last_edge;
    if (idle_before > TO) idle_before = TO;
    if (sel_edge) m_last_edge = m_k;
    for (int p = 0; p < 2; p++) begin
      if (!six_btn[p])               m_phase[p] = 0;
      else if (sel_rise)             m_phase[p] = (idle_before >= TO) ? 0 : (m_phase[p] + 1) % 4;
      else if (m_k - m_last_edge >= TO) m_phase[p] = 0;
    end
    m_sel_h = {m_sel_h[2], m_sel_h[1], joy_sel};
    m_clk_h = {m_clk_h[2], m_clk_h[1], joy_clk};
    m_ld_h  = {m_ld_h[2],  m_ld_h[1],  joy_load_n};
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else          m_step();
    end
  end

  // Compare every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_joy_data",   32'(joy_data),   32'(m_frame[0]));
        check("cyc_joy1_phase", 32'(joy1_phase), 32'(m_phase[0]));
        check("cyc_joy2_phase", 32'(joy2_phase), 32'(m_phase[1]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    joy_clk = 1'b1;
    cyc(4);
    joy_clk = 1'b0;
    cyc(4);
  endtask

  // ser[15] holds the first serial bit
  task automatic read_out(output logic [15:0] ser);
    for (int i = 0; i < 16; i++) begin
      ser[15-i] = joy_data;
      pulse();
    end
  endtask

  task automatic scan(output logic [15:0] ser);
    joy_load_n = 1'b0;
    cyc(5);
    joy_load_n = 1'b1;
    cyc(4);
    read_out(ser);
  endtask

  task automatic sel_pair();
    joy_sel = 1'b0;
    cyc(6);
    joy_sel = 1'b1;
    cyc(6);
  endtask

  logic [15:0] ser;

  initial begin
    reset_n = 1'b0;
    joy1_i = 12'hFFF; joy2_i = 12'hFFF; six_btn = 2'b00;
    joy_sel = 1'b1; joy_clk = 1'b0; joy_load_n = 1'b1;
    cyc(1);
    chk_en = 1'b1;

    // Reset with random activity on every input
    for (int i = 0; i < 6; i++) begin
      joy1_i = 12'($urandom); joy2_i = 12'($urandom); six_btn = 2'($urandom);
      joy_sel = 1'($urandom); joy_clk = 1'($urandom); joy_load_n = 1'($urandom);
      cyc(2);
    end
    check("rst_joy_data", 32'(joy_data), 32'd1);
    check("rst_joy1_phase", 32'(joy1_phase), 32'd0);
    check("rst_joy2_phase", 32'(joy2_phase), 32'd0);
    joy_sel = 1'b1; joy_clk = 1'b0; joy_load_n = 1'b1; six_btn = 2'b00;
    joy1_i = 12'hFFF; joy2_i = 12'hFFF;
    cyc(2);
    reset_n = 1'b1;
    cyc(20);
    check("idle_joy_data", 32'(joy_data), 32'd1);

    // 3-button scan, select high: pad1 U pressed, pad2 B pressed
    joy1_i = 12'hFFE; joy2_i = 12'hFEF;
    cyc(4);
    scan(ser);
    check("scan3_sel_hi", 32'(ser), 32'(16'b1111_1110_1110_1111));
    check("scan3_tail", 32'(joy_data), 32'd1);

    // Same pads, select low
    joy_sel = 1'b0;
    cyc(4);
    scan(ser);
    check("scan3_sel_lo", 32'(ser), 32'(16'b1111_0010_1111_0011));

    // Load held low while joy_clk pulses: nothing shifts
    joy_sel = 1'b1;
    cyc(4);
    joy_load_n = 1'b0;
    cyc(5);
    for (int i = 0; i < 3; i++) begin
      joy_clk = 1'b1;
      cyc(3);
      check("load_hold_bit0", 32'(joy_data), 32'd1);
      joy_clk = 1'b0;
      cyc(3);
    end
    // Clock edge lands on the last load-low cycle: the frame must stay aligned
    joy_clk = 1'b1;
    cyc(1);
    joy_load_n = 1'b1;
    cyc(4);
    joy_clk = 1'b0;
    cyc(4);
    read_out(ser);
    check("collide_frame", 32'(ser), 32'(16'b1111_1110_1110_1111));

    // 6-button sequence on pad 1: Z and M pressed
    six_btn = 2'b01; joy1_i = 12'h6FF; joy2_i = 12'hFFF;
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      joy_sel = 1'b0;
      cyc(6);
      check("six_phase_seq", 32'(joy1_phase), 32'(i));
      if (i == 2) begin
        scan(ser);
        check("six_ph2_sel_lo", 32'(ser), 32'(16'b1111_0000_1111_0011));
      end
      joy_sel = 1'b1;
      cyc(6);
      if (i == 2) begin
        check("six_ph3_reached", 32'(joy1_phase), 32'd3);
        scan(ser);
        check("six_ph3_sel_hi", 32'(ser), 32'(16'b1111_0110_1111_1111));
      end
    end
    check("six_wrap", 32'(joy1_phase), 32'd0);
    check("six_pad2_3btn", 32'(joy2_phase), 32'd0);

    // Timeout from phase 2
    sel_pair();
    sel_pair();
    check("to_ph2", 32'(joy1_phase), 32'd2);
    cyc(TO - 20);
    check("to_not_yet", 32'(joy1_phase), 32'd2);
    cyc(24);
    check("to_fired", 32'(joy1_phase), 32'd0);

    // Rise at idle TIMEOUT-1 still advances
    sel_pair();
    sel_pair();
    joy_sel = 1'b0;
    cyc(TO);
    joy_sel = 1'b1;
    cyc(6);
    check("to_edge_minus1", 32'(joy1_phase), 32'd3);

    // One cycle later the timeout has already won
    sel_pair();
    sel_pair();
    sel_pair();
    check("to_ph2_again", 32'(joy1_phase), 32'd2);
    joy_sel = 1'b0;
    cyc(TO + 1);
    joy_sel = 1'b1;
    cyc(6);
    check("to_edge_plus0", 32'(joy1_phase), 32'd0);

    // Reset in the middle of a frame
    joy1_i = 12'hFFE; joy2_i = 12'hFEF;
    sel_pair();
    check("mid_phase1", 32'(joy1_phase), 32'd1);
    joy_load_n = 1'b0;
    cyc(5);
    joy_load_n = 1'b1;
    cyc(4);
    repeat (7) pulse();
    check("mid_bit7", 32'(joy_data), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(joy_data), 32'd1);
    check("mid_rst_phase1", 32'(joy1_phase), 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    scan(ser);
    check("mid_reload", 32'(ser), 32'(16'b1111_1110_1110_1111));

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
